// File: rtl/tmds_channel_encoder.sv
// Single-channel DVI/HDMI TMDS 8b/10b encoder with a 3-stage pipeline (A: capture, B: q_m, C: symbol + disparity).
// Define TMDS_TERC4_EN to add the ade/aux ports and TERC4 data-island symbols; otherwise blanking emits control tokens only.
module tmds_channel_encoder (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
`ifdef TMDS_TERC4_EN
    input  logic       ade,
    input  logic [3:0] aux,
`endif
    output logic [9:0] dout
);

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            2'b11:   t = 10'b1010101011;
            default: t = 10'b1101010100;
        endcase
        return t;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4_symbol(input logic [3:0] a);
        logic [9:0] t;
        case (a)
            4'd0:    t = 10'b1010011100;
            4'd1:    t = 10'b1001100011;
            4'd2:    t = 10'b1011100100;
            4'd3:    t = 10'b1011100010;
            4'd4:    t = 10'b0101110001;
            4'd5:    t = 10'b0100011110;
            4'd6:    t = 10'b0110001110;
            4'd7:    t = 10'b0100111100;
            4'd8:    t = 10'b1011001100;
            4'd9:    t = 10'b0100111001;
            4'd10:   t = 10'b0110011100;
            4'd11:   t = 10'b1011000110;
            4'd12:   t = 10'b1010001110;
            4'd13:   t = 10'b1001110001;
            4'd14:   t = 10'b0101100011;
            4'd15:   t = 10'b1011000011;
            default: t = 10'b1010011100;
        endcase
        return t;
    endfunction
`endif

    logic [3:0]        w_n1d;
    logic              w_use_xnor;
    logic [8:0]        w_qm;
    logic [3:0]        w_n0q;
    logic signed [4:0] w_n1q_s;
    logic signed [4:0] w_n0q_s;
    logic signed [4:0] w_qm8_x2;
    logic signed [4:0] w_nqm8_x2;
    logic              w_cnt_pos;
    logic              w_cnt_neg;
    logic [9:0]        w_sym;
    logic signed [4:0] w_cnt_next;

    logic [7:0]        r_a_din;
    logic              r_a_xnor;
    logic              r_a_de;
    logic [1:0]        r_a_c;
    logic [8:0]        r_b_qm;
    logic [3:0]        r_b_n1q;
    logic              r_b_de;
    logic [1:0]        r_b_c;
    logic [9:0]        r_dout;
    logic signed [4:0] r_cnt;
`ifdef TMDS_TERC4_EN
    logic              r_a_ade;
    logic [3:0]        r_a_aux;
    logic              r_b_ade;
    logic [3:0]        r_b_aux;
`endif

    assign w_n1d      = ones8(din);
    assign w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !din[0]);
    assign w_qm       = qm_encode(r_a_din, r_a_xnor);

    assign w_n0q      = 4'd8 - r_b_n1q;
    assign w_n1q_s    = $signed({1'b0, r_b_n1q});
    assign w_n0q_s    = $signed({1'b0, w_n0q});
    assign w_qm8_x2   = $signed({3'b000, r_b_qm[8], 1'b0});
    assign w_nqm8_x2  = $signed({3'b000, ~r_b_qm[8], 1'b0});
    assign w_cnt_pos  = (r_cnt != 5'sd0) && !r_cnt[4];
    assign w_cnt_neg  = r_cnt[4];

    // Stage A: capture pixel, XOR/XNOR decision and sideband
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_din  <= 8'd0;
            r_a_xnor <= 1'b0;
            r_a_de   <= 1'b0;
            r_a_c    <= 2'b00;
`ifdef TMDS_TERC4_EN
            r_a_ade  <= 1'b0;
            r_a_aux  <= 4'd0;
`endif
        end else begin
            r_a_din  <= din;
            r_a_xnor <= w_use_xnor;
            r_a_de   <= de;
            r_a_c    <= {c1, c0};
`ifdef TMDS_TERC4_EN
            r_a_ade  <= ade;
            r_a_aux  <= aux;
`endif
        end
    end

    // Stage B: transition-minimised word q_m and its ones count
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_qm  <= 9'd0;
            r_b_n1q <= 4'd0;
            r_b_de  <= 1'b0;
            r_b_c   <= 2'b00;
`ifdef TMDS_TERC4_EN
            r_b_ade <= 1'b0;
            r_b_aux <= 4'd0;
`endif
        end else begin
            r_b_qm  <= w_qm;
            r_b_n1q <= ones8(w_qm[7:0]);
            r_b_de  <= r_a_de;
            r_b_c   <= r_a_c;
`ifdef TMDS_TERC4_EN
            r_b_ade <= r_a_ade;
            r_b_aux <= r_a_aux;
`endif
        end
    end

    // Stage C selection: DC-balancing symbol choice; any blanking symbol restarts disparity at zero
    always_comb begin
        w_sym      = 10'd0;
        w_cnt_next = 5'sd0;
        if (r_b_de) begin
            if ((r_cnt == 5'sd0) || (r_b_n1q == w_n0q)) begin
                w_sym      = {~r_b_qm[8], r_b_qm[8], r_b_qm[8] ? r_b_qm[7:0] : ~r_b_qm[7:0]};
                w_cnt_next = r_b_qm[8] ? (r_cnt + w_n1q_s - w_n0q_s) : (r_cnt + w_n0q_s - w_n1q_s);
            end else if ((w_cnt_pos && (r_b_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > r_b_n1q))) begin
                w_sym      = {1'b1, r_b_qm[8], ~r_b_qm[7:0]};
                w_cnt_next = r_cnt + w_qm8_x2 + w_n0q_s - w_n1q_s;
            end else begin
                w_sym      = {1'b0, r_b_qm[8], r_b_qm[7:0]};
                w_cnt_next = r_cnt + w_n1q_s - w_n0q_s - w_nqm8_x2;
            end
        end else begin
`ifdef TMDS_TERC4_EN
            if (r_b_ade) begin
                w_sym = terc4_symbol(r_b_aux);
            end else begin
                w_sym = ctrl_token(r_b_c);
            end
`else
            w_sym = ctrl_token(r_b_c);
`endif
            w_cnt_next = 5'sd0;
        end
    end

    // Stage C: registered symbol and running disparity
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= 10'd0;
            r_cnt  <= 5'sd0;
        end else begin
            r_dout <= w_sym;
            r_cnt  <= w_cnt_next;
        end
    end

    assign dout = r_dout;

endmodule
